calc2_port_issuer: RTL and testbench
====================================

CALC2_PORT_ISSUER -- requirements
Module: calc2_port_issuer

Interface
REQ-001 SHALL have parameter NUM_TAGS, default 4, meaning the number of outstanding requests allowed (range 1..4; tag width fixed at 2).
REQ-002 SHALL have port c_clk  in  1  single rising-edge clock for the whole block.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports s_valid in 1, s_ready out 1, s_cmd in 4, s_op1 in 32, s_op2 in 32  upstream transaction handshake.
REQ-005 SHALL have ports req_cmd_out out 4, req_data_out out 32, req_tag_out out 2  request lane into one calc2_top port.
REQ-006 SHALL have ports dut_resp_in in 2, dut_data_in in 32, dut_tag_in in 2  response lane from the same calc2_top port.
REQ-007 SHALL have ports cpl_valid out 1, cpl_resp out 2, cpl_data out 32, cpl_tag out 2, cpl_cmd out 4  completion record to the downstream checker.
REQ-008 SHALL have ports outstanding out 3 (count of busy tags) and err_unexpected out 1 (one-cycle pulse).

Function
REQ-009 SHALL use FSM states IDLE, BEAT1, BEAT2; all req_* outputs SHALL be registered.
REQ-010 SHALL drive s_ready = (state is IDLE or BEAT2) AND at least one tag below NUM_TAGS is free.
REQ-011 SHALL treat s_valid & s_ready at rising edge k as accept: capture cmd/op1/op2, allocate lowest-numbered free tag, go to BEAT1.
REQ-012 BEAT1 (cycle after edge k) SHALL drive req_cmd_out=s_cmd, req_data_out=op1, req_tag_out=allocated tag; next state BEAT2.
REQ-013 BEAT2 SHALL drive req_cmd_out=0, req_data_out=op2, req_tag_out=0; next state BEAT1 if an accept occurs at that edge, else IDLE.
REQ-014 IDLE SHALL drive all req_* outputs to 0; sustained throughput is one request per 2 cycles.
REQ-015 SHALL forward s_cmd unchanged, including codes other than 1/2/5/6; a response with resp 2 is expected for those codes.
REQ-016 SHALL store cmd per tag in a tag table, with the busy bit set at the accept edge.
REQ-017 When dut_resp_in != 0 at edge m and tag dut_tag_in is busy: in the cycle after m, cpl_valid=1 with resp/data/tag copied and cpl_cmd from the table; the tag is freed at edge m.
REQ-018 When dut_resp_in != 0 and the tag is not busy: err_unexpected=1 for one cycle, cpl_valid stays 0, the table is unchanged.
REQ-019 dut_resp_in == 0 SHALL be ignored regardless of data/tag values.
REQ-020 Allocation SHALL see only tags free before the edge; a tag freed at edge m is first allocatable at edge m+1.
REQ-021 Simultaneous accept and completion at the same edge SHALL both take effect, and outstanding SHALL be net unchanged.
REQ-022 cpl_valid SHALL have no backpressure and is a single-cycle pulse per completion.
REQ-023 outstanding SHALL equal the popcount of busy bits, registered and never exceeding NUM_TAGS.

Reset
REQ-024 While reset is low: state=IDLE, all tags free, outstanding=0, s_ready=0, and all req_*, cpl_* and err_unexpected outputs=0.
REQ-025 Reset asserted mid-BEAT1/BEAT2 SHALL abort the request with no second beat; responses arriving after release for pre-reset tags SHALL raise err_unexpected.
REQ-026 s_ready SHALL first rise in the cycle after the first rising edge following reset deassertion.

Verification
REQ-027 Accept cmd=1, op1=0x56, op2=0x103 -> BEAT1 drives 1/0x56/tag0, BEAT2 drives 0/0x103/0; resp 1, data 0x159, tag 0 -> cpl_valid with cmd 1, outstanding returns to 0.
REQ-028 Accept cmd=2, op1=0x158, op2=0x12 back-to-back with REQ-027 traffic -> tag 1 used, BEAT1 follows BEAT2 without an IDLE cycle; resp 1, data 0x146 -> completion tag 1, cmd 2.
REQ-029 Four accepts with no responses -> tags 0,1,2,3 allocated, outstanding=4, s_ready=0; a response on tag 2 -> s_ready returns one cycle later and the next accept gets tag 2.
REQ-030 resp 1 on tag 3 with no outstanding requests -> err_unexpected pulses once, cpl_valid=0, outstanding=0.
REQ-031 Reset low during BEAT1 of cmd=5 -> req_* outputs become 0 immediately, no BEAT2 occurs; a later resp on that tag -> err_unexpected.
REQ-032 With all 4 tags busy, a completion on tag 0 and s_valid high in the same cycle -> no accept at that edge, accept with tag 0 at the next edge.

Source files
------------

// File: rtl/calc2_port_issuer.sv
// Two-beat request issuer for one calc2_top port with a tag table that
// tracks outstanding requests and pairs responses back to their command.
module calc2_port_issuer #(
  parameter int NUM_TAGS = 4
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [3:0]  s_cmd,
  input  logic [31:0] s_op1,
  input  logic [31:0] s_op2,
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  output logic [1:0]  req_tag_out,
  input  logic [1:0]  dut_resp_in,
  input  logic [31:0] dut_data_in,
  input  logic [1:0]  dut_tag_in,
  output logic        cpl_valid,
  output logic [1:0]  cpl_resp,
  output logic [31:0] cpl_data,
  output logic [1:0]  cpl_tag,
  output logic [3:0]  cpl_cmd,
  output logic [2:0]  outstanding,
  output logic        err_unexpected
);

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_e;

  localparam logic [3:0] TAG_MASK = 4'((1 << NUM_TAGS) - 1);

  state_e      state_q, state_d;
  logic [3:0]  busy_q, busy_d;
  logic [3:0]  cmd_tbl_q [4];
  logic [31:0] op2_q, op2_d;
  logic        en_q;
  logic [3:0]  req_cmd_q, req_cmd_d;
  logic [31:0] req_data_q, req_data_d;
  logic [1:0]  req_tag_q, req_tag_d;
  logic        cpl_valid_q, cpl_valid_d;
  logic [1:0]  cpl_resp_q, cpl_resp_d;
  logic [31:0] cpl_data_q, cpl_data_d;
  logic [1:0]  cpl_tag_q, cpl_tag_d;
  logic [3:0]  cpl_cmd_q, cpl_cmd_d;
  logic [2:0]  out_q, out_d;
  logic        err_q, err_d;

  logic [3:0]  free;
  logic [1:0]  alloc;
  logic        acc;
  logic        rsp;
  logic        hit;

  assign free = ~busy_q & TAG_MASK;

  always_comb begin
    alloc = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (free[i]) alloc = 2'(i);
    end
  end

  // en_q holds ready low until the first edge after reset release
  assign s_ready = en_q && (state_q != BEAT1) && (|free);
  assign acc     = s_valid && s_ready;
  assign rsp     = dut_resp_in != 2'd0;
  assign hit     = rsp && busy_q[dut_tag_in];

  always_comb begin
    busy_d = busy_q;
    if (hit) busy_d[dut_tag_in] = 1'b0;
    if (acc) busy_d[alloc] = 1'b1;
    out_d = {2'b0, busy_d[0]} + {2'b0, busy_d[1]}
          + {2'b0, busy_d[2]} + {2'b0, busy_d[3]};
  end

  always_comb begin
    state_d    = IDLE;
    op2_d      = op2_q;
    req_cmd_d  = 4'd0;
    req_data_d = 32'd0;
    req_tag_d  = 2'd0;
    unique case (1'b1)
      acc: begin
        state_d    = BEAT1;
        op2_d      = s_op2;
        req_cmd_d  = s_cmd;
        req_data_d = s_op1;
        req_tag_d  = alloc;
      end
      (state_q == BEAT1): begin
        state_d    = BEAT2;
        req_data_d = op2_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpl_valid_d = hit;
    cpl_resp_d  = hit ? dut_resp_in : 2'd0;
    cpl_data_d  = hit ? dut_data_in : 32'd0;
    cpl_tag_d   = hit ? dut_tag_in : 2'd0;
    cpl_cmd_d   = hit ? cmd_tbl_q[dut_tag_in] : 4'd0;
    err_d       = rsp && !busy_q[dut_tag_in];
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      busy_q      <= 4'd0;
      op2_q       <= 32'd0;
      en_q        <= 1'b0;
      req_cmd_q   <= 4'd0;
      req_data_q  <= 32'd0;
      req_tag_q   <= 2'd0;
      cpl_valid_q <= 1'b0;
      cpl_resp_q  <= 2'd0;
      cpl_data_q  <= 32'd0;
      cpl_tag_q   <= 2'd0;
      cpl_cmd_q   <= 4'd0;
      out_q       <= 3'd0;
      err_q       <= 1'b0;
      for (int i = 0; i < 4; i++) cmd_tbl_q[i] <= 4'd0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      op2_q       <= op2_d;
      en_q        <= 1'b1;
      req_cmd_q   <= req_cmd_d;
      req_data_q  <= req_data_d;
      req_tag_q   <= req_tag_d;
      cpl_valid_q <= cpl_valid_d;
      cpl_resp_q  <= cpl_resp_d;
      cpl_data_q  <= cpl_data_d;
      cpl_tag_q   <= cpl_tag_d;
      cpl_cmd_q   <= cpl_cmd_d;
      out_q       <= out_d;
      err_q       <= err_d;
      if (acc) cmd_tbl_q[alloc] <= s_cmd;
    end
  end

  assign req_cmd_out    = req_cmd_q;
  assign req_data_out   = req_data_q;
  assign req_tag_out    = req_tag_q;
  assign cpl_valid      = cpl_valid_q;
  assign cpl_resp       = cpl_resp_q;
  assign cpl_data       = cpl_data_q;
  assign cpl_tag        = cpl_tag_q;
  assign cpl_cmd        = cpl_cmd_q;
  assign outstanding    = out_q;
  assign err_unexpected = err_q;

endmodule

// File: tb/tb_calc2_port_issuer.sv
// Bench for calc2_port_issuer: transaction-level model checked every
// cycle, directed scenarios with literal pins, then random traffic.
module tb_calc2_port_issuer;

  localparam int NT = 4;

  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [3:0]  s_cmd = '0;
  logic [31:0] s_op1 = '0;
  logic [31:0] s_op2 = '0;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  req_tag_out;
  logic [1:0]  dut_resp_in = '0;
  logic [31:0] dut_data_in = '0;
  logic [1:0]  dut_tag_in = '0;
  logic        cpl_valid;
  logic [1:0]  cpl_resp;
  logic [31:0] cpl_data;
  logic [1:0]  cpl_tag;
  logic [3:0]  cpl_cmd;
  logic [2:0]  outstanding;
  logic        err_unexpected;

  calc2_port_issuer #(.NUM_TAGS(NT)) dut (
    .c_clk(c_clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_cmd(s_cmd),
    .s_op1(s_op1), .s_op2(s_op2),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
    .req_tag_out(req_tag_out),
    .dut_resp_in(dut_resp_in), .dut_data_in(dut_data_in),
    .dut_tag_in(dut_tag_in),
    .cpl_valid(cpl_valid), .cpl_resp(cpl_resp), .cpl_data(cpl_data),
    .cpl_tag(cpl_tag), .cpl_cmd(cpl_cmd),
    .outstanding(outstanding), .err_unexpected(err_unexpected)
  );

  always #5 c_clk = ~c_clk;

  int total = 0;
  int bad = 0;
  bit running = 1'b1;

  // model: which tags hold a live request, and what the port shows next
  bit [3:0]    mbusy;
  logic [3:0]  mcmd [4];
  bit          men;
  bit          mfirst;
  bit          macc;
  logic [31:0] mop2;
  logic [3:0]  e_rcmd;
  logic [31:0] e_rdata;
  logic [1:0]  e_rtag;
  logic        e_cv;
  logic [1:0]  e_cr;
  logic [31:0] e_cd;
  logic [1:0]  e_ct;
  logic [3:0]  e_cc;
  logic        e_err;

  function automatic bit m_ready();
    bit any = 0;
    for (int i = 0; i < NT; i++) if (!mbusy[i]) any = 1;
    return men && !mfirst && any;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(mbusy[i]);
    return n;
  endfunction

  task automatic m_clear();
    mbusy = '0; men = 0; mfirst = 0; macc = 0; mop2 = '0;
    e_rcmd = '0; e_rdata = '0; e_rtag = '0;
    e_cv = 0; e_cr = '0; e_cd = '0; e_ct = '0; e_cc = '0; e_err = 0;
  endtask

  task automatic model_step();
    int at;
    if (!reset) begin
      m_clear();
      return;
    end
    macc = s_valid && m_ready();
    at = 0;
    for (int i = NT - 1; i >= 0; i--) if (!mbusy[i]) at = i;
    e_cv = 0; e_cr = '0; e_cd = '0; e_ct = '0; e_cc = '0; e_err = 0;
    if (dut_resp_in != 0) begin
      if (mbusy[dut_tag_in]) begin
        e_cv = 1; e_cr = dut_resp_in; e_cd = dut_data_in;
        e_ct = dut_tag_in; e_cc = mcmd[dut_tag_in];
        mbusy[dut_tag_in] = 0;
      end else begin
        e_err = 1;
      end
    end
    if (macc) begin
      mbusy[at] = 1; mcmd[at] = s_cmd; mop2 = s_op2;
      e_rcmd = s_cmd; e_rdata = s_op1; e_rtag = 2'(at);
      mfirst = 1;
    end else if (mfirst) begin
      e_rcmd = '0; e_rdata = mop2; e_rtag = '0;
      mfirst = 0;
    end else begin
      e_rcmd = '0; e_rdata = '0; e_rtag = '0;
    end
    men = 1;
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge c_clk);
      model_step();
    end
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge c_clk);
      if (running) begin
        if (!reset) begin
          chk("rdy", s_ready, 0);
          chk("rcmd", req_cmd_out, 0);
          chk("rdata", req_data_out, 0);
          chk("rtag", req_tag_out, 0);
          chk("cv", cpl_valid, 0);
          chk("cr", cpl_resp, 0);
          chk("cd", cpl_data, 0);
          chk("ct", cpl_tag, 0);
          chk("cc", cpl_cmd, 0);
          chk("outst", outstanding, 0);
          chk("err", err_unexpected, 0);
        end else begin
          chk("rdy", s_ready, 32'(m_ready()));
          chk("rcmd", req_cmd_out, e_rcmd);
          chk("rdata", req_data_out, e_rdata);
          chk("rtag", req_tag_out, e_rtag);
          chk("cv", cpl_valid, e_cv);
          chk("cr", cpl_resp, e_cr);
          chk("cd", cpl_data, e_cd);
          chk("ct", cpl_tag, e_ct);
          chk("cc", cpl_cmd, e_cc);
          chk("outst", outstanding, 32'(m_count()));
          chk("err", err_unexpected, e_err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge c_clk);
    #2;
  endtask

  task automatic send(input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b);
    s_valid = 1; s_cmd = c; s_op1 = a; s_op2 = b;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (macc) begin
        s_valid = 0;
        return;
      end
    end
    s_valid = 0;
    total++; bad++;
    $display("FAIL send_timeout: got no accept want accept at %0t", $time);
  endtask

  task automatic respond(input logic [1:0] r, input logic [31:0] d,
                         input logic [1:0] t);
    dut_resp_in = r; dut_data_in = d; dut_tag_in = t;
    tick();
    dut_resp_in = '0;
    dut_data_in = $urandom;
    dut_tag_in = 2'($urandom_range(3));
  endtask

  initial begin
    int sel;
    int pick;
    repeat (3) tick();
    @(negedge c_clk);
    chk("p_rst_rdy", s_ready, 0);
    chk("p_rst_out", outstanding, 0);
    tick();
    reset = 1;
    @(negedge c_clk);
    chk("p_rdy_pre", s_ready, 0);
    tick();
    @(negedge c_clk);
    chk("p_rdy_up", s_ready, 1);

    send(4'd1, 32'h56, 32'h103);
    @(negedge c_clk);
    chk("p_b1_cmd", req_cmd_out, 1);
    chk("p_b1_data", req_data_out, 32'h56);
    chk("p_b1_tag", req_tag_out, 0);
    s_valid = 1; s_cmd = 4'd2; s_op1 = 32'h158; s_op2 = 32'h12;
    tick();
    @(negedge c_clk);
    chk("p_b2_cmd", req_cmd_out, 0);
    chk("p_b2_data", req_data_out, 32'h103);
    chk("p_b2_rdy", s_ready, 1);
    tick();
    chk("p_acc2", macc, 1);
    s_valid = 0;
    @(negedge c_clk);
    chk("p_b1b_cmd", req_cmd_out, 2);
    chk("p_b1b_data", req_data_out, 32'h158);
    chk("p_b1b_tag", req_tag_out, 1);
    chk("p_out2", outstanding, 2);
    respond(2'd1, 32'h159, 2'd0);
    @(negedge c_clk);
    chk("p_c0_v", cpl_valid, 1);
    chk("p_c0_cmd", cpl_cmd, 1);
    chk("p_c0_data", cpl_data, 32'h159);
    respond(2'd1, 32'h146, 2'd1);
    @(negedge c_clk);
    chk("p_c1_cmd", cpl_cmd, 2);
    chk("p_c1_tag", cpl_tag, 1);
    chk("p_out0", outstanding, 0);
    @(negedge c_clk);
    chk("p_c_pulse", cpl_valid, 0);

    for (int i = 0; i < 4; i++) begin
      send(4'd6, 32'(i), 32'(i + 10));
      @(negedge c_clk);
      chk("p_fill_tag", req_tag_out, 32'(i));
    end
    repeat (2) tick();
    @(negedge c_clk);
    chk("p_full_out", outstanding, 4);
    chk("p_full_rdy", s_ready, 0);
    respond(2'd1, 32'h7, 2'd2);
    @(negedge c_clk);
    chk("p_free_rdy", s_ready, 1);
    send(4'd3, 32'hA, 32'hB);
    @(negedge c_clk);
    chk("p_reuse_tag", req_tag_out, 2);
    chk("p_fwd_cmd", req_cmd_out, 3);

    repeat (3) tick();
    s_valid = 1; s_cmd = 4'd4; s_op1 = 32'h44; s_op2 = 32'h45;
    dut_resp_in = 2'd1; dut_data_in = 32'h9; dut_tag_in = 2'd0;
    tick();
    dut_resp_in = 2'd0;
    chk("p_same_noacc", macc, 0);
    @(negedge c_clk);
    chk("p_same_cmd", req_cmd_out, 0);
    chk("p_same_cv", cpl_valid, 1);
    tick();
    chk("p_next_acc", macc, 1);
    s_valid = 0;
    @(negedge c_clk);
    chk("p_next_tag", req_tag_out, 0);
    chk("p_next_cmd", req_cmd_out, 4);

    repeat (2) tick();
    for (int t = 0; t < 4; t++) respond(2'd2, 32'(t), 2'(t));
    @(negedge c_clk);
    chk("p_drain", outstanding, 0);
    respond(2'd1, 32'h55, 2'd3);
    @(negedge c_clk);
    chk("p_unexp_err", err_unexpected, 1);
    chk("p_unexp_cv", cpl_valid, 0);
    @(negedge c_clk);
    chk("p_unexp_pulse", err_unexpected, 0);

    send(4'd5, 32'h1, 32'h2);
    reset = 0;
    #1;
    chk("p_abort_cmd", req_cmd_out, 0);
    chk("p_abort_tag", req_tag_out, 0);
    repeat (2) tick();
    reset = 1;
    repeat (3) tick();
    @(negedge c_clk);
    chk("p_abort_nob2", req_data_out, 0);
    respond(2'd1, 32'h3, 2'd0);
    @(negedge c_clk);
    chk("p_stale_err", err_unexpected, 1);

    for (int c = 0; c < 600; c++) begin
      if (c == 300) reset = 0;
      if (c == 302) reset = 1;
      s_valid = 1'($urandom_range(1));
      s_cmd = 4'($urandom);
      s_op1 = $urandom;
      s_op2 = $urandom;
      sel = $urandom_range(9);
      dut_data_in = $urandom;
      dut_tag_in = 2'($urandom_range(3));
      dut_resp_in = '0;
      if (sel < 5 && mbusy != 0) begin
        pick = $urandom_range(3);
        while (!mbusy[pick]) pick = (pick + 1) % 4;
        dut_tag_in = 2'(pick);
        dut_resp_in = 2'($urandom_range(1, 3));
      end else if (sel < 6) begin
        dut_resp_in = 2'($urandom_range(1, 3));
      end
      tick();
    end
    s_valid = 0;
    dut_resp_in = '0;
    tick();
    @(negedge c_clk);
    #1;
    running = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
